shad_reg_hist: RTL and testbench

- Parametrised successor to the single-entry shadow/scan register.
- A system register captures functional data. A multi-entry shadow history bank snapshots the system register on capture pulses, keeping the newest `depth` snapshots.
- The history is readable by index and serially scannable through a single scan chain.
- Used for debug and observability of datapath registers. Everything runs on one clock, so there is no separate shadow clock.

---
 rtl/shad_reg_hist.sv | 103 ++++++++++
 tb/tb_shad_reg_hist.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/shad_reg_hist.sv
// System register with an optional multi-entry shadow history bank.
// The bank snapshots the system register on capture and doubles as one scan chain.
module shad_reg_hist #(
  parameter int width        = 8,
  parameter int depth        = 4,
  parameter int bld_shad_reg = 1,
  localparam int sel_w       = $clog2(depth),
  localparam int cnt_w       = sel_w + 1
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic [width-1:0] datain,
  input  logic             load_en,
  input  logic             capture,
  input  logic             ovf_clr,
  input  logic             SI,
  input  logic             SE,
  input  logic [sel_w-1:0] rd_sel,
  output logic [width-1:0] sys_out,
  output logic [width-1:0] shad_out,
  output logic             SO,
  output logic [cnt_w-1:0] hist_count,
  output logic             overflow
);

  localparam int chain_w = depth * width;

  logic [width-1:0] sys_q, sys_d;

  always_comb begin
    sys_d = sys_q;
    if (load_en) sys_d = datain;
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) sys_q <= '0;
    else       sys_q <= sys_d;
  end

  assign sys_out = sys_q;

  generate
    if (bld_shad_reg != 0) begin : g_hist
      // Entry i occupies hist_q[i*width +: width]; entry 0 sits at the chain input end.
      logic [chain_w-1:0] hist_q, hist_d;
      logic [cnt_w-1:0]   cnt_q, cnt_d;
      logic               ovf_q, ovf_d;
      logic               ovf_set;
      logic [width-1:0]   rd_data;

      always_comb begin
        hist_d  = hist_q;
        cnt_d   = cnt_q;
        ovf_set = 1'b0;
        if (SE) begin
          hist_d = {hist_q[chain_w-2:0], SI};
        end else if (capture) begin
          hist_d = {hist_q[chain_w-width-1:0], sys_q};
          if (cnt_q == cnt_w'(depth)) ovf_set = 1'b1;
          else                        cnt_d   = cnt_q + 1'b1;
        end
      end

      // A new overflow event outranks a clear arriving in the same cycle.
      always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (ovf_set) ovf_d = 1'b1;
      end

      always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
          hist_q <= '0;
          cnt_q  <= '0;
          ovf_q  <= 1'b0;
        end else begin
          hist_q <= hist_d;
          cnt_q  <= cnt_d;
          ovf_q  <= ovf_d;
        end
      end

      // Out-of-range indices fall through to zero.
      always_comb begin
        rd_data = '0;
        for (int i = 0; i < depth; i++) begin
          if (int'(rd_sel) == i) rd_data = hist_q[i*width +: width];
        end
      end

      assign shad_out   = rd_data;
      assign SO         = hist_q[chain_w-1];
      assign hist_count = cnt_q;
      assign overflow   = ovf_q;
    end else begin : g_no_hist
      assign shad_out   = '0;
      assign SO         = 1'b0;
      assign hist_count = '0;
      assign overflow   = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_shad_reg_hist.sv
// Directed bench for shad_reg_hist: one instance with the history bank, one without,
// both driven by the same inputs.
module tb_shad_reg_hist;

  logic       sys_clk = 1'b0;
  logic       reset;
  logic [7:0] datain;
  logic       load_en, capture, ovf_clr, SI, SE;
  logic [1:0] rd_sel;

  logic [7:0] sys_out, shad_out;
  logic       SO, overflow;
  logic [2:0] hist_count;

  logic [7:0] nb_sys_out, nb_shad_out;
  logic       nb_SO, nb_overflow;
  logic [2:0] nb_hist_count;

  int total = 0;
  int bad   = 0;
  logic [31:0] word;

  always #5 sys_clk = ~sys_clk;

  shad_reg_hist #(.width(8), .depth(4), .bld_shad_reg(1)) u_dut (
    .sys_clk(sys_clk), .reset(reset), .datain(datain), .load_en(load_en),
    .capture(capture), .ovf_clr(ovf_clr), .SI(SI), .SE(SE), .rd_sel(rd_sel),
    .sys_out(sys_out), .shad_out(shad_out), .SO(SO),
    .hist_count(hist_count), .overflow(overflow)
  );

  shad_reg_hist #(.width(8), .depth(4), .bld_shad_reg(0)) u_nb (
    .sys_clk(sys_clk), .reset(reset), .datain(datain), .load_en(load_en),
    .capture(capture), .ovf_clr(ovf_clr), .SI(SI), .SE(SE), .rd_sel(rd_sel),
    .sys_out(nb_sys_out), .shad_out(nb_shad_out), .SO(nb_SO),
    .hist_count(nb_hist_count), .overflow(nb_overflow)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] v);
    datain  = v;
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
  endtask

  task automatic cap();
    capture = 1'b1;
    tick();
    capture = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] idx, input logic [7:0] exp);
    rd_sel = idx;
    #1;
    chk(tag, 32'(shad_out), 32'(exp));
  endtask

  initial begin
    reset = 1'b1; datain = '0; load_en = 0; capture = 0; ovf_clr = 0;
    SI = 0; SE = 0; rd_sel = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_sys", 32'(sys_out), 32'h0);
    chk("rst_shad", 32'(shad_out), 32'h0);
    chk("rst_cnt", 32'(hist_count), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_so", 32'(SO), 32'h0);

    // Fill past full with 0xA5 so SO and overflow are both 1 before the reset hits.
    load(8'hA5);
    repeat (5) cap();
    chk("pre_cnt", 32'(hist_count), 32'h4);
    chk("pre_ovf", 32'(overflow), 32'h1);
    chk("pre_so", 32'(SO), 32'h1);
    rd("pre_rd0", 2'd0, 8'hA5);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_sys", 32'(sys_out), 32'h0);
    chk("arst_shad", 32'(shad_out), 32'h0);
    chk("arst_cnt", 32'(hist_count), 32'h0);
    chk("arst_ovf", 32'(overflow), 32'h0);
    chk("arst_so", 32'(SO), 32'h0);
    tick();
    reset = 1'b0;

    // Capture ordering, newest first.
    load(8'h11); cap();
    load(8'h22); cap();
    load(8'h33); cap();
    rd("ord_rd0", 2'd0, 8'h33);
    rd("ord_rd1", 2'd1, 8'h22);
    rd("ord_rd2", 2'd2, 8'h11);
    rd("ord_rd3", 2'd3, 8'h00);
    chk("ord_cnt", 32'(hist_count), 32'h3);

    // Same-cycle load and capture snapshots the old value.
    load(8'h10);
    datain = 8'h20; load_en = 1'b1; capture = 1'b1;
    tick();
    load_en = 1'b0; capture = 1'b0;
    rd("lc_rd0", 2'd0, 8'h10);
    rd("lc_rd1", 2'd1, 8'h33);
    chk("lc_sys", 32'(sys_out), 32'h20);
    chk("lc_cnt", 32'(hist_count), 32'h4);
    chk("lc_ovf", 32'(overflow), 32'h0);

    // Overflow from a clean start.
    reset = 1'b1; tick(); reset = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      load(8'(v));
      cap();
    end
    chk("ov_cnt", 32'(hist_count), 32'h4);
    chk("ov_flag", 32'(overflow), 32'h1);
    rd("ov_rd0", 2'd0, 8'h05);
    rd("ov_rd1", 2'd1, 8'h04);
    rd("ov_rd2", 2'd2, 8'h03);
    rd("ov_rd3", 2'd3, 8'h02);
    load(8'h06);
    capture = 1'b1; ovf_clr = 1'b1;
    tick();
    capture = 1'b0; ovf_clr = 1'b0;
    chk("ov_setwins", 32'(overflow), 32'h1);
    rd("ov_rd0b", 2'd0, 8'h06);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ov_clr", 32'(overflow), 32'h0);
    chk("ov_cnt2", 32'(hist_count), 32'h4);
    chk("nb_ov_cnt", 32'(nb_hist_count), 32'h0);
    chk("nb_ov_ovf", 32'(nb_overflow), 32'h0);
    chk("nb_ov_sys", 32'(nb_sys_out), 32'h06);

    // Scan in the word MSB first so the chain ends holding it verbatim
    // (entry3 = high byte); a capture and a load are mixed in mid-scan.
    word = 32'hDEADBEEF;
    SE = 1'b1;
    for (int i = 0; i < 32; i++) begin
      SI = word[31-i];
      if (i == 10) capture = 1'b1;
      if (i == 20) begin datain = 8'h77; load_en = 1'b1; end
      tick();
      capture = 1'b0;
      load_en = 1'b0;
    end
    rd("sc_rd3", 2'd3, 8'hDE);
    rd("sc_rd2", 2'd2, 8'hAD);
    rd("sc_rd1", 2'd1, 8'hBE);
    rd("sc_rd0", 2'd0, 8'hEF);
    chk("sc_cnt", 32'(hist_count), 32'h4);
    chk("sc_ovf", 32'(overflow), 32'h0);
    chk("sc_sys", 32'(sys_out), 32'h77);

    SI = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("so_bit%0d", i), 32'(SO), 32'(word[31-i]));
      chk($sformatf("nb_so_bit%0d", i), 32'(nb_SO), 32'h0);
      tick();
    end
    SE = 1'b0;
    rd("sc_flush", 2'd0, 8'h00);

    chk("nb_shad", 32'(nb_shad_out), 32'h0);
    chk("nb_cnt", 32'(nb_hist_count), 32'h0);
    chk("nb_ovf", 32'(nb_overflow), 32'h0);
    chk("nb_sys", 32'(nb_sys_out), 32'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
